// File: rtl/fpu_pkg.sv
// FP32 field layout, defaults and small helpers shared by the FPU dispatch path.
// Imported by fadd, fadd_result_fifo and fadd_dispatch.
package fpu_pkg;

  localparam int FP_W      = 32;
  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int SIGN_BIT  = 31;
  localparam int EXP_LSB   = 23;
  localparam int EXP_MSB   = 30;
  localparam int TAG_W_DEF = 6;

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [FP_W-1:0] s;
    logic [FP_W-1:0] t;
  } fadd_op_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fadd.sv
// Two-stage IEEE-754 single adder: input register, then align/add/round.
// Round to nearest even; any NaN result is the canonical quiet NaN.
module fadd
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] s,
  input  logic [31:0] t,
  output logic [31:0] d
);

  logic [31:0] s_q, t_q;

  always_ff @(posedge clk) begin
    s_q <= s;
    t_q <= t;
  end

  logic [31:0] a, b;
  logic [7:0]  ea, eb, dexp;
  logic [23:0] ma, mb;
  logic [53:0] al;
  logic [26:0] mx, my, nm;
  logic [27:0] sum;
  logic [9:0]  e;
  logic [4:0]  p, lz, k;
  logic [24:0] r;
  logic        eff_sub, inc;
  logic        a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    a = s_q;
    b = t_q;
    // a always carries the larger magnitude, so it sets the result sign
    if (t_q[30:0] > s_q[30:0]) begin
      a = t_q;
      b = s_q;
    end
    ea   = (a[EXP_MSB:EXP_LSB] == '0) ? 8'd1 : a[EXP_MSB:EXP_LSB];
    eb   = (b[EXP_MSB:EXP_LSB] == '0) ? 8'd1 : b[EXP_MSB:EXP_LSB];
    ma   = {a[EXP_MSB:EXP_LSB] != '0, a[FRAC_W-1:0]};
    mb   = {b[EXP_MSB:EXP_LSB] != '0, b[FRAC_W-1:0]};
    dexp = ea - eb;
    mx   = {ma, 3'b000};
    al   = {mb, 30'b0} >> dexp;
    if (dexp > 8'd26) my = {26'b0, |mb};
    else              my = al[53:27] | {26'b0, |al[26:0]};

    eff_sub = a[SIGN_BIT] ^ b[SIGN_BIT];
    sum = eff_sub ? {1'b0, mx} - {1'b0, my}
                  : {1'b0, mx} + {1'b0, my};

    p = '0;
    for (int i = 0; i < 28; i++)
      if (sum[i]) p = 5'(i);

    e  = {2'b00, ea};
    nm = sum[26:0];
    lz = '0;
    k  = '0;
    if (sum[27]) begin
      nm = {sum[27:2], sum[1] | sum[0]};
      e  = e + 10'd1;
    end else if (p < 5'd26) begin
      lz = 5'd26 - p;
      k  = ({5'b0, lz} < e - 10'd1) ? lz : 5'(e - 10'd1);
      nm = 27'(sum << k);
      e  = e - {5'b0, k};
    end

    inc = nm[2] & (nm[1] | nm[0] | nm[3]);
    r   = {1'b0, nm[26:3]} + {24'b0, inc};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'd1;
    end

    a_nan = (a[EXP_MSB:EXP_LSB] == 8'hFF) && (a[FRAC_W-1:0] != '0);
    b_nan = (b[EXP_MSB:EXP_LSB] == 8'hFF) && (b[FRAC_W-1:0] != '0);
    a_inf = (a[EXP_MSB:EXP_LSB] == 8'hFF) && (a[FRAC_W-1:0] == '0);
    b_inf = (b[EXP_MSB:EXP_LSB] == 8'hFF) && (b[FRAC_W-1:0] == '0);

    if (a_nan || b_nan || (a_inf && b_inf && eff_sub))
      d = QNAN;
    else if (a_inf || b_inf)
      d = a;
    else if (sum == '0)
      d = eff_sub ? 32'h0 : {a[SIGN_BIT], 31'b0};
    else if (e >= 10'd255)
      d = {a[SIGN_BIT], 8'hFF, 23'b0};
    else
      d = {a[SIGN_BIT], r[23] ? e[7:0] : 8'h00, r[22:0]};
  end

endmodule

// File: rtl/fadd_result_fifo.sv
// Result FIFO toward writeback holding {tag, result} entries.
// Pointers carry one wrap bit to tell full from empty; memory is not reset.
module fadd_result_fifo
  import fpu_pkg::*;
#(
  parameter int W     = 38,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         full;

  assign empty_o = (wr_q == rd_q);
  assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i)             wr_d = wr_q + (AW+1)'(1);
    if (pop_i && !empty_o)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  // occupancy credit upstream means a push never meets a full FIFO
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rstn_i || clr_i)
    !(push_i && full && !pop_i));

endmodule

// File: rtl/fadd_dispatch.sv
// Valid/ready front end for the fadd pipe: credit admission, valid/tag pipe, result FIFO.
// Define FADD_DISPATCH_FLUSH_EN to add the flush port that discards all work.
module fadd_dispatch
  import fpu_pkg::*;
#(
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef FADD_DISPATCH_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sub,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [31:0]      req_s,
  input  logic [31:0]      req_t,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_d,
  output logic             busy
);

  localparam int            OW      = clog2(DEPTH + 1);
  localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);

  logic kill;
`ifdef FADD_DISPATCH_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  fadd_op_t           op_q, op_d;
  logic [LATENCY-1:0] v_q, v_d;
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [TAG_W-1:0]   tag_d [LATENCY];
  logic [OW-1:0]      occ_q, occ_d;
  logic               accept, pop, empty;
  logic [31:0]        fadd_d;
  logic [TAG_W+31:0]  rdata;

  // occ counts in-flight plus buffered ops, so a push always has a slot
  assign req_ready = (occ_q < OCC_MAX) && !kill;
  assign accept    = req_valid && req_ready;
  assign res_valid = !empty;
  assign pop       = res_valid && res_ready;
  assign busy      = (occ_q != '0);
  assign {res_tag, res_d} = rdata;

  always_comb begin
    op_d = op_q;
    if (accept) begin
      op_d.s = req_s;
      op_d.t = req_t ^ {req_sub, 31'b0};
    end
    v_d      = {v_q[LATENCY-2:0], accept};
    tag_d[0] = accept ? req_tag : tag_q[0];
    for (int i = 1; i < LATENCY; i++)
      tag_d[i] = tag_q[i-1];
    occ_d = occ_q;
    unique case ({accept, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || kill) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q  <= op_d;
    tag_q <= tag_d;
  end

  fadd u_fadd (
    .clk (clk),
    .s   (op_q.s),
    .t   (op_q.t),
    .d   (fadd_d)
  );

  fadd_result_fifo #(
    .W     (TAG_W + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .clr_i   (kill),
    .push_i  (v_q[LATENCY-1]),
    .pop_i   (pop),
    .wdata_i ({tag_q[LATENCY-1], fadd_d}),
    .rdata_o (rdata),
    .empty_o (empty)
  );

endmodule
